// File: rtl/serial_add_sequencer_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer:
// FSM state encoding, legal operand widths and the bit-counter width helper.
package serial_add_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    // Counter must be able to hold WIDTH itself so it never wraps mid-operation.
    function automatic int ctr_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_add_sequencer_fa_bit.sv
// Single-bit full adder used by the serial datapath: sum bit and majority carry.
module serial_fa_bit
    import serial_add_sequencer_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder/subtractor. Operands are captured on an accepted start,
// then one bit per clock is pushed LSB-first through a single full adder.
// The result, carry-out and signed overflow are published together on the
// last shift edge and held until the next operation completes.
module serial_add_sequencer
    import serial_add_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             bit_valid,
    output logic             a_bit,
    output logic             b_bit,
    output logic             c_bit,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int             CW       = ctr_width(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] acc_q;     // working sum register, filled from the MSB side
    logic [WIDTH-1:0] sum_q;     // published result, only touched on the last edge
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;

    logic             fa_sum;
    logic             fa_carry;

    // Serial taps are forced low whenever no bit is in flight.
    assign busy      = busy_q;
    assign ready     = ~busy_q;
    assign bit_valid = busy_q;
    assign a_bit     = busy_q & a_sr_q[0];
    assign b_bit     = busy_q & b_sr_q[0];
    assign c_bit     = busy_q & carry_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    serial_fa_bit u_fa (
        .a_i  (a_bit),
        .b_i  (b_bit),
        .c_i  (c_bit),
        .s_o  (fa_sum),
        .co_o (fa_carry)
    );

    // Control FSM and serial datapath: capture on accept, shift one bit per edge, publish on the last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                SHIFT: begin
                    acc_q   <= {fa_sum, acc_q[WIDTH-1:1]};
                    carry_q <= fa_carry;
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        sum_q   <= {fa_sum, acc_q[WIDTH-1:1]};
                        cout_q  <= fa_carry;
                        // Carry into the MSB differing from carry out of it means signed overflow.
                        ovf_q   <= carry_q ^ fa_carry;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept; DONE lasts exactly one cycle.
                    done_q <= 1'b0;
                    if (start) begin
                        a_sr_q  <= a;
                        // Subtract is a + ~b + 1, so invert B and force the carry-in.
                        b_sr_q  <= op_sub ? ~b : b;
                        carry_q <= op_sub | cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Testbench for serial_add_sequencer: directed cases on 4/8/16-bit instances
// and a randomized regression on 2/4/8/16/64-bit instances against an
// arithmetic reference model.
module tb_serial_add_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int rnd_left = 5;

    localparam int NW   = 5;
    localparam int NOPS = 1000;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- directed 4-bit instance ----------------
    logic       r4, st4, sub4, ci4;
    logic [3:0] a4, b4, s4;
    logic       rdy4, bsy4, bv4, ab4, bb4, cb4, dn4, co4, ov4;

    serial_add_sequencer #(.WIDTH(4)) u_d4 (
        .clk(clk), .reset(r4), .start(st4), .op_sub(sub4), .a(a4), .b(b4), .cin(ci4),
        .ready(rdy4), .busy(bsy4), .bit_valid(bv4), .a_bit(ab4), .b_bit(bb4), .c_bit(cb4),
        .done(dn4), .sum(s4), .cout(co4), .ovf(ov4)
    );

    // ---------------- directed 8-bit instance ----------------
    logic       r8, st8, sub8, ci8;
    logic [7:0] a8, b8, s8;
    logic       rdy8, bsy8, bv8, ab8, bb8, cb8, dn8, co8, ov8;

    serial_add_sequencer #(.WIDTH(8)) u_d8 (
        .clk(clk), .reset(r8), .start(st8), .op_sub(sub8), .a(a8), .b(b8), .cin(ci8),
        .ready(rdy8), .busy(bsy8), .bit_valid(bv8), .a_bit(ab8), .b_bit(bb8), .c_bit(cb8),
        .done(dn8), .sum(s8), .cout(co8), .ovf(ov8)
    );

    // ---------------- directed 16-bit instance ----------------
    logic        r16, st16, sub16, ci16;
    logic [15:0] a16, b16, s16;
    logic        rdy16, bsy16, bv16, ab16, bb16, cb16, dn16, co16, ov16;

    serial_add_sequencer #(.WIDTH(16)) u_d16 (
        .clk(clk), .reset(r16), .start(st16), .op_sub(sub16), .a(a16), .b(b16), .cin(ci16),
        .ready(rdy16), .busy(bsy16), .bit_valid(bv16), .a_bit(ab16), .b_bit(bb16), .c_bit(cb16),
        .done(dn16), .sum(s16), .cout(co16), .ovf(ov16)
    );

    typedef struct {
        bit       op;
        bit [7:0] a;
        bit [7:0] b;
        bit       cin;
        bit [7:0] sum;
        bit       cout;
        bit       ovf;
    } vec8_t;

    // 4-bit add with bit-stream observation
    task automatic t_stream4();
        bit [3:0] ea;
        bit [3:0] eb;
        ea = 4'b1011;
        eb = 4'b0110;
        a4 = 4'b1011; b4 = 4'b0110; ci4 = 1'b0; sub4 = 1'b0; st4 = 1'b1;
        @(posedge clk); #1;
        st4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sub4 = 1'b1; ci4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("stream_a_bit", ab4, ea[i]);
            check("stream_b_bit", bb4, eb[i]);
            check("stream_done_early", dn4, 0);
            @(posedge clk); #1;
        end
        check("stream_done", dn4, 1);
        check("stream_sum", s4, 4'b0001);
        check("stream_cout", co4, 1);
        check("stream_ovf", ov4, 0);
        check("stream_idle_bits", {bv4, ab4, bb4, cb4}, 0);
        $display("W=4 add a=b b=6 cin=0 -> sum=%h cout=%0d ovf=%0d", s4, co4, ov4);
        @(posedge clk); #1;
        check("stream_done_width", dn4, 0);
        check("stream_sum_held", s4, 4'b0001);
        sub4 = 1'b0; ci4 = 1'b0;
    endtask

    // back-to-back operations and start pulses during SHIFT
    task automatic t_b2b4();
        int dn_cnt;
        a4 = 4'd3; b4 = 4'd4; sub4 = 1'b0; ci4 = 1'b0; st4 = 1'b1;
        @(posedge clk); #1;
        a4 = 4'd9; b4 = 4'd9;
        for (int i = 0; i < 4; i++) begin
            check("b2b_busy1", bsy4, 1);
            @(posedge clk); #1;
        end
        check("b2b_done1", dn4, 1);
        check("b2b_sum1", s4, 4'd7);
        check("b2b_cout1", co4, 0);
        check("b2b_busy_gap", bsy4, 0);
        check("b2b_ready_done", rdy4, 1);
        $display("W=4 add a=3 b=4 -> sum=%h cout=%0d ovf=%0d", s4, co4, ov4);
        @(posedge clk); #1;
        st4 = 1'b0;
        check("b2b_accept2", bsy4, 1);
        check("b2b_done_drop", dn4, 0);
        check("b2b_sum_hold", s4, 4'd7);
        repeat (3) begin @(posedge clk); #1; end
        check("b2b_done2_early", dn4, 0);
        @(posedge clk); #1;
        check("b2b_done2", dn4, 1);
        check("b2b_sum2", s4, 4'd2);
        check("b2b_cout2", co4, 1);
        check("b2b_ovf2", ov4, 1);
        $display("W=4 add a=9 b=9 -> sum=%h cout=%0d ovf=%0d", s4, co4, ov4);
        @(posedge clk); #1;

        a4 = 4'd5; b4 = 4'd2; st4 = 1'b1;
        @(posedge clk); #1;
        st4 = 1'b0;
        @(posedge clk); #1;
        st4 = 1'b1; a4 = 4'd15; b4 = 4'd15; sub4 = 1'b1;
        @(posedge clk); #1;
        st4 = 1'b0; sub4 = 1'b0;
        check("ign_no_early_done", dn4, 0);
        repeat (2) begin @(posedge clk); #1; end
        check("ign_done", dn4, 1);
        check("ign_sum", s4, 4'd7);
        $display("W=4 add a=5 b=2 (start pulse mid-shift) -> sum=%h", s4);
        dn_cnt = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (dn4) dn_cnt++;
        end
        check("ign_extra_done", dn_cnt, 0);
        check("ign_not_busy", bsy4, 0);
    endtask

    // 8-bit vector table
    task automatic t_table8();
        vec8_t tbl[10];
        tbl[0] = '{1'b1, 8'd5,  8'd7,  1'b0, 8'hFE, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 8'h00, 8'h80, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            int n;
            a8 = tbl[i].a; b8 = tbl[i].b; sub8 = tbl[i].op; ci8 = tbl[i].cin; st8 = 1'b1;
            @(posedge clk); #1;
            st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); ci8 = 1'($urandom);
            check("tbl_c_bit_first", cb8, tbl[i].op ? 1'b1 : tbl[i].cin);
            n = 0;
            while (!dn8 && n < 12) begin
                @(posedge clk); #1;
                n++;
            end
            check("tbl_latency", n, 8);
            check("tbl_sum", s8, tbl[i].sum);
            check("tbl_cout", co8, tbl[i].cout);
            check("tbl_ovf", ov8, tbl[i].ovf);
            $display("W=8 sub=%0d a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d",
                     tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, s8, co8, ov8);
            @(posedge clk); #1;
            check("tbl_done_width", dn8, 0);
        end
    endtask

    // 16-bit reset in the middle of an operation
    task automatic t_reset16();
        int n;
        int dn_seen;
        a16 = 16'h1234; b16 = 16'h1111; sub16 = 1'b0; ci16 = 1'b0; st16 = 1'b1;
        @(posedge clk); #1;
        st16 = 1'b0;
        n = 0;
        while (!dn16 && n < 20) begin @(posedge clk); #1; n++; end
        check("r16_latency", n, 16);
        check("r16_sum_pre", s16, 16'h2345);
        $display("W=16 add a=1234 b=1111 -> sum=%h cout=%0d", s16, co16);
        @(posedge clk); #1;

        a16 = 16'h00FF; b16 = 16'h0F0F; st16 = 1'b1;
        @(posedge clk); #1;
        st16 = 1'b0;
        dn_seen = 0;
        repeat (7) begin
            @(posedge clk); #1;
            if (dn16) dn_seen++;
        end
        check("r16_busy_before", bsy16, 1);
        r16 = 1'b1; st16 = 1'b1;
        #1;
        check("r16_ready", rdy16, 1);
        check("r16_busy", bsy16, 0);
        check("r16_bits", {bv16, ab16, bb16, cb16}, 0);
        check("r16_sum", s16, 0);
        check("r16_cout_ovf", {co16, ov16}, 0);
        check("r16_done", dn16, 0);
        repeat (2) begin
            @(posedge clk); #1;
            if (dn16) dn_seen++;
            check("r16_start_in_reset", bsy16, 0);
        end
        a16 = 16'hFFFF; b16 = 16'h0001; sub16 = 1'b0; ci16 = 1'b0;
        r16 = 1'b0;
        #1;
        check("r16_no_async_accept", bsy16, 0);
        @(posedge clk); #1;
        check("r16_first_accept", bsy16, 1);
        st16 = 1'b0;
        n = 0;
        while (!dn16 && n < 20) begin @(posedge clk); #1; n++; end
        check("r16_no_done_on_abort", dn_seen, 0);
        check("r16_latency2", n, 16);
        check("r16_sum2", s16, 16'h0000);
        check("r16_cout2", co16, 1);
        check("r16_ovf2", ov16, 0);
        $display("W=16 add a=ffff b=0001 after reset -> sum=%h cout=%0d ovf=%0d", s16, co16, ov16);
        @(posedge clk); #1;
    endtask

    // ---------------- randomized regression, one instance per width ----------------
    for (genvar gi = 0; gi < NW; gi++) begin : g_rnd
        localparam int W = (gi == 0) ? 2 : (gi == 1) ? 4 : (gi == 2) ? 8 : (gi == 3) ? 16 : 64;

        logic         rst, st, sub, ci;
        logic [W-1:0] ra, rb, s;
        logic         rdy, bsy, bv, ab, bb, cb, dn, co, ov;

        serial_add_sequencer #(.WIDTH(W)) u_dut (
            .clk(clk), .reset(rst), .start(st), .op_sub(sub), .a(ra), .b(rb), .cin(ci),
            .ready(rdy), .busy(bsy), .bit_valid(bv), .a_bit(ab), .b_bit(bb), .c_bit(cb),
            .done(dn), .sum(s), .cout(co), .ovf(ov)
        );

        // Reference: plain integer arithmetic on wider words.
        function automatic void model(input bit op, input logic [W-1:0] x, input logic [W-1:0] y,
                                      input bit c, output logic [W-1:0] es, output logic ec,
                                      output logic eo);
            logic [W:0]          full;
            logic signed [W+1:0] sx, sy, sr, lim;
            sx  = (W+2)'(signed'(x));
            sy  = (W+2)'(signed'(y));
            lim = 1;
            lim = lim <<< (W - 1);
            if (op) begin
                es = x - y;
                ec = (x >= y);
                sr = sx - sy;
            end else begin
                full = (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
                es   = full[W-1:0];
                ec   = full[W];
                sr   = sx + sy + (W+2)'(c);
            end
            eo = (sr >= lim) || (sr < -lim);
        endfunction

        initial begin : run
            logic [W-1:0] es, prev, x, y;
            logic         ec, eo;
            bit           op, c, chain;
            int           n;
            rst = 1'b1; st = 1'b1; sub = 1'b0; ci = 1'b0; ra = '0; rb = '0;
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b0;
            prev  = '0;
            chain = 1'b0;
            for (int k = 0; k < NOPS; k++) begin
                op = 1'($urandom_range(1));
                c  = 1'($urandom_range(1));
                x  = W'({$urandom, $urandom});
                y  = W'({$urandom, $urandom});
                model(op, x, y, c, es, ec, eo);
                st = 1'b1; sub = op; ci = c; ra = x; rb = y;
                @(posedge clk); #1;
                check("rnd_accept", bsy, 1);
                check("rnd_done_width", dn, 0);
                check("rnd_sum_held", s, prev);
                n = 0;
                while (!dn && n < W + 4) begin
                    st  = 1'($urandom_range(1));
                    sub = 1'($urandom_range(1));
                    ci  = 1'($urandom_range(1));
                    ra  = W'({$urandom, $urandom});
                    rb  = W'({$urandom, $urandom});
                    @(posedge clk); #1;
                    n++;
                end
                check("rnd_latency", n, W);
                check("rnd_sum", s, es);
                check("rnd_cout", co, ec);
                check("rnd_ovf", ov, eo);
                $display("W=%0d op#%0d sub=%0d a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d",
                         W, k, op, x, y, c, s, co, ov);
                prev  = es;
                chain = 1'($urandom_range(1));
                if (!chain) begin
                    st = 1'b0;
                    @(posedge clk); #1;
                    check("rnd_done_drop", dn, 0);
                    check("rnd_idle_ready", rdy, 1);
                end
            end
            st = 1'b0;
            rnd_left--;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int waited;
        r4 = 1'b1; r8 = 1'b1; r16 = 1'b1;
        st4 = 1'b0; st8 = 1'b0; st16 = 1'b0;
        sub4 = 1'b0; sub8 = 1'b0; sub16 = 1'b0;
        ci4 = 1'b0; ci8 = 1'b0; ci16 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", rdy4, 1);
        check("rst_busy", bsy4, 0);
        check("rst_done", dn4, 0);
        check("rst_bits", {bv4, ab4, bb4, cb4}, 0);
        check("rst_sum", s4, 0);
        check("rst_cout_ovf", {co4, ov4}, 0);
        r4 = 1'b0; r8 = 1'b0; r16 = 1'b0;
        @(posedge clk); #1;

        t_stream4();
        t_b2b4();
        t_table8();
        t_reset16();

        waited = 0;
        while (rnd_left > 0 && waited < 90000) begin
            @(posedge clk);
            waited++;
        end
        total++;
        if (rnd_left != 0) begin
            bad++;
            $display("FAIL rnd_timeout: got %0d unfinished widths expected 0", rnd_left);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_sequencer.md
SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..64.
REQ-002 Ports SHALL be:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request to begin an operation; honoured only when ready=1.
- op_sub  in  1  0 = add (a+b+cin); 1 = subtract (a-b).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when op_sub=1.
- ready  out  1  high when a start will be accepted.
- busy  out  1  high while bits are being shifted.
- bit_valid  out  1  qualifies a_bit, b_bit and c_bit.
- a_bit  out  1  current serial bit of A, LSB first.
- b_bit  out  1  current serial bit of B, after inversion when op_sub=1.
- c_bit  out  1  carry currently fed to the bit adder.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result, held until the next accepted start.
- cout  out  1  final carry-out, held with sum.
- ovf  out  1  signed overflow, held with sum.

Function
REQ-003 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-004 ready SHALL be 1 in IDLE and DONE, and 0 in SHIFT.
REQ-005 An accepting edge (start=1 and ready=1) SHALL capture:
- a into the A shift register;
- b (or ~b when op_sub=1) into the B shift register;
- cin (or 1 when op_sub=1) into the carry flop;
- the bit counter cleared to 0;
- a transition to SHIFT.
REQ-006 In SHIFT:
- bit_valid=1, busy=1;
- a_bit = A register bit 0, b_bit = B register bit 0, c_bit = carry flop.
REQ-007 Each SHIFT edge SHALL:
- shift the sum bit (a_bit^b_bit^c_bit) into the sum shift register from the MSB side;
- load the carry flop with maj(a_bit, b_bit, c_bit);
- shift the A and B registers right with zero fill;
- increment the counter.
REQ-008 The SHIFT edge with counter=WIDTH-1 SHALL:
- update sum and cout;
- set ovf = c_bit XOR final carry-out;
- move to DONE.
REQ-009 Timing SHALL be: exactly WIDTH SHIFT cycles; done=1 exactly one cycle, starting WIDTH edges after the accepting edge.
REQ-010 From DONE: start=1 → accept per REQ-005 (back-to-back, no idle cycle); otherwise → IDLE.
REQ-011 start SHALL be ignored in SHIFT; a, b, op_sub and cin SHALL be ignored outside accepting edges.
REQ-012 Outside SHIFT, a_bit, b_bit, c_bit and bit_valid SHALL be 0.
REQ-013 sum, cout and ovf SHALL change only on the REQ-008 edge or on reset.
REQ-014 Arithmetic SHALL be modulo 2^WIDTH. Subtract SHALL give sum = a-b mod 2^WIDTH, with cout=1 meaning no borrow.
REQ-015 The counter width SHALL be clog2(WIDTH+1), with no wrap inside an operation.

Reset
REQ-016 reset SHALL asynchronously force:
- state IDLE, counter 0;
- shift registers, carry flop, sum, cout and ovf to 0;
- done, busy, bit_valid, a_bit, b_bit and c_bit to 0;
- ready to 1.
REQ-017 Reset mid-SHIFT SHALL abort the operation with no done pulse. The first start after deassertion SHALL behave as from power-up.
REQ-018 start asserted during reset SHALL be ignored. The first edge after deassertion with start=1 SHALL be accepted.

Structure
REQ-019 A shared package SHALL hold the FSM state enum (IDLE/SHIFT/DONE), the WIDTH limits and the counter-width function.
REQ-020 The single-bit full adder (sum and majority carry) SHALL be a sub-module named serial_fa_bit, instantiated once. Everything else SHALL stay in serial_add_sequencer.
REQ-021 The total size SHALL be 120-400 lines of RTL; there SHALL be no memories and no multi-bit adders.

Verification
REQ-022 WIDTH=4:
- add a=4'b1011, b=4'b0110, cin=0 → a_bit stream 1,1,0,1 and b_bit stream 0,1,1,0 over 4 cycles;
- done on cycle 4 after acceptance;
- sum=4'b0001, cout=1, ovf=0.
REQ-023 WIDTH=8, subtract a=8'd5, b=8'd7 → sum=8'hFE, cout=0, ovf=0; c_bit=1 in the first SHIFT cycle.
REQ-024 WIDTH=8, add 8'h7F+8'h01, cin=0 → sum=8'h80, cout=0, ovf=1.
REQ-025 WIDTH=4:
- back-to-back: start held high → second operation accepted in the DONE cycle, busy low exactly one cycle between operations;
- start pulse during SHIFT → ignored, no extra done.
REQ-026 WIDTH=16:
- reset asserted after 7 SHIFT cycles → immediate return to IDLE, all outputs 0, no done;
- next operation 16'hFFFF+16'h0001 → sum=0, cout=1.
REQ-027 Random regression across WIDTH ∈ {2, 4, 8, 16, 64}, ≥1000 operations per WIDTH, compared against a reference model for sum, cout, ovf and done timing.
